// File: rtl/jt12_bus_writer_if.sv
// Request handshake plus YM2612-style bus; the writer uses the slave view, the
// requester/chip side (host logic or bench) uses the master view.
interface jt12_bus_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_part;
  logic [7:0] req_reg;
  logic [7:0] req_data;
  logic [1:0] ym_addr;
  logic [7:0] ym_din;
  logic       ym_cs_n;
  logic       ym_wr_n;
  logic [7:0] ym_dout;
  logic       busy;
  logic       timeout;

  modport master (
    output req_valid, req_part, req_reg, req_data, ym_dout,
    input  req_ready, ym_addr, ym_din, ym_cs_n, ym_wr_n, busy, timeout
  );

  modport slave (
    input  req_valid, req_part, req_reg, req_data, ym_dout,
    output req_ready, ym_addr, ym_din, ym_cs_n, ym_wr_n, busy, timeout
  );
endinterface

// File: rtl/jt12_bus_writer.sv
// Register-write sequencer: address strobe, data strobe, then busy-flag poll; min 2*WR_LEN+3 cen
// ticks per write, one request at a time (req_ready only in IDLE), all outputs registered.
module jt12_bus_writer #(
  parameter int WR_LEN   = 2,
  parameter int POLL_MAX = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  jt12_bus_writer_if.slave       bus
);
  typedef enum logic [2:0] {IDLE, ADR, GAP1, DAT, GAP2, POLL} state_t;

  localparam logic [3:0] STRB_LAST = 4'(WR_LEN - 1);
  localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

  state_t     state_q;
  logic [3:0] strb_cnt_q;
  logic [7:0] poll_cnt_q;
  logic       part_q;
  logic [7:0] reg_q;
  logic [7:0] data_q;
  logic       req_ready_q;
  logic       busy_q;
  logic       timeout_q;
  logic       ym_cs_n_q;
  logic       ym_wr_n_q;
  logic [1:0] ym_addr_q;
  logic [7:0] ym_din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      strb_cnt_q  <= 4'd0;
      poll_cnt_q  <= 8'd0;
      part_q      <= 1'b0;
      reg_q       <= 8'd0;
      data_q      <= 8'd0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      ym_cs_n_q   <= 1'b1;
      ym_wr_n_q   <= 1'b1;
      ym_addr_q   <= 2'b00;
      ym_din_q    <= 8'd0;
    end else if (cen) begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            part_q      <= bus.req_part;
            reg_q       <= bus.req_reg;
            data_q      <= bus.req_data;
            timeout_q   <= 1'b0;
            state_q     <= ADR;
            strb_cnt_q  <= 4'd0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            ym_cs_n_q   <= 1'b0;
            ym_wr_n_q   <= 1'b0;
            ym_addr_q   <= {bus.req_part, 1'b0};
            ym_din_q    <= bus.req_reg;
          end
        end
        ADR: begin
          if (strb_cnt_q == STRB_LAST) begin
            state_q    <= GAP1;
            strb_cnt_q <= 4'd0;
            ym_cs_n_q  <= 1'b1;
            ym_wr_n_q  <= 1'b1;
          end else begin
            strb_cnt_q <= strb_cnt_q + 4'd1;
          end
        end
        GAP1: begin
          state_q    <= DAT;
          strb_cnt_q <= 4'd0;
          ym_cs_n_q  <= 1'b0;
          ym_wr_n_q  <= 1'b0;
          ym_addr_q  <= {part_q, 1'b1};
          ym_din_q   <= data_q;
        end
        DAT: begin
          if (strb_cnt_q == STRB_LAST) begin
            state_q    <= GAP2;
            strb_cnt_q <= 4'd0;
            ym_cs_n_q  <= 1'b1;
            ym_wr_n_q  <= 1'b1;
          end else begin
            strb_cnt_q <= strb_cnt_q + 4'd1;
          end
        end
        GAP2: begin
          state_q    <= POLL;
          poll_cnt_q <= 8'd0;
          ym_cs_n_q  <= 1'b0;
          ym_wr_n_q  <= 1'b1;
          ym_addr_q  <= 2'b00;
          ym_din_q   <= 8'd0;
        end
        POLL: begin
          // Chip ready, or this busy sample is the POLL_MAX-th: either way the write is over.
          if (!bus.ym_dout[7] || poll_cnt_q == POLL_LAST) begin
            timeout_q   <= bus.ym_dout[7];
            state_q     <= IDLE;
            poll_cnt_q  <= 8'd0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            ym_cs_n_q   <= 1'b1;
            ym_wr_n_q   <= 1'b1;
            ym_addr_q   <= 2'b00;
            ym_din_q    <= 8'd0;
          end else begin
            poll_cnt_q <= poll_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;
  assign bus.ym_cs_n   = ym_cs_n_q;
  assign bus.ym_wr_n   = ym_wr_n_q;
  assign bus.ym_addr   = ym_addr_q;
  assign bus.ym_din    = ym_din_q;
endmodule

// File: tb/tb_jt12_bus_writer.sv
// Bench for jt12_bus_writer: each write is predicted as a sequence of bus phases whose
// lengths follow from WR_LEN, the chip's busy-poll count and POLL_MAX.
module tb_jt12_bus_writer;
  localparam int WR_LEN   = 2;
  localparam int POLL_MAX = 255;
  localparam logic [14:0] FULL = 15'h7fff;
  localparam logic [14:0] NO_AD = 15'h7c00;
  localparam logic [14:0] NO_D  = 15'h7f00;

  logic clk = 1'b0;
  logic rst_n;
  logic cen;
  int   checks = 0;
  int   errors = 0;
  bit   model_to = 1'b0;

  jt12_bus_writer_if bus_if ();

  jt12_bus_writer #(.WR_LEN(WR_LEN), .POLL_MAX(POLL_MAX)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cen  (cen),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // {timeout, req_ready, busy, cs_n, wr_n, addr[1:0], din[7:0]}
  function automatic logic [14:0] obs();
    return {bus_if.timeout, bus_if.req_ready, bus_if.busy, bus_if.ym_cs_n, bus_if.ym_wr_n,
            bus_if.ym_addr, bus_if.ym_din};
  endfunction

  function automatic logic [14:0] idle_vec(bit to);
    return {to, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00};
  endfunction

  // Expected bus state after the k-th cen tick counted from the accepting tick (k=0).
  function automatic logic [14:0] exp_snap(input int k, input bit p, input logic [7:0] rg,
                                           input logic [7:0] dt, input int pc, input bit to,
                                           output logic [14:0] m);
    int d_end;
    int p_end;
    d_end = 2 * WR_LEN + 1;
    p_end = d_end + 1 + pc;
    m = FULL;
    if (k < WR_LEN)      return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, p, 1'b0, rg};
    if (k == WR_LEN)     begin m = NO_AD; return {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h0}; end
    if (k < d_end)       return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, p, 1'b1, dt};
    if (k == d_end)      begin m = NO_AD; return {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h0}; end
    if (k < p_end)       begin m = NO_D; return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 8'h00}; end
    return idle_vec(to);
  endfunction

  // Issue one write; the chip reports busy for the first nbusy polls. cdiv = clk per cen tick.
  task automatic do_write(input string name, input bit p, input logic [7:0] rg,
                          input logic [7:0] dt, input int nbusy, input int cdiv,
                          input bit keep_valid, input int abort_at);
    int pc;
    int total;
    int j;
    bit to;
    logic [14:0] e, m, pe, pm, got;
    pc    = (nbusy >= POLL_MAX) ? POLL_MAX : nbusy + 1;
    to    = (nbusy >= POLL_MAX);
    total = 2 * WR_LEN + 2 + pc;
    pe    = idle_vec(model_to);
    pm    = FULL;
    bus_if.req_valid = 1'b1;
    bus_if.req_part  = p;
    bus_if.req_reg   = rg;
    bus_if.req_data  = dt;
    for (int k = 0; k <= total; k++) begin
      j = k - 1 - (2 * WR_LEN + 2);
      bus_if.ym_dout = {(j >= 0 && j < nbusy), 7'($urandom)};
      for (int i = 1; i < cdiv; i++) begin
        cen = 1'b0;
        @(posedge clk); #1;
        got = obs();
        checks++;
        if ((got & pm) !== (pe & pm)) begin
          errors++;
          $display("FAIL %s hold k=%0d clk=%0d got=%h exp=%h mask=%h", name, k, i, got, pe, pm);
        end
      end
      cen = 1'b1;
      @(posedge clk); #1;
      if (k == 0) begin
        if (keep_valid) begin
          bus_if.req_part = 1'($urandom);
          bus_if.req_reg  = 8'($urandom);
          bus_if.req_data = 8'($urandom);
        end else begin
          bus_if.req_valid = 1'b0;
        end
      end
      e   = exp_snap(k, p, rg, dt, pc, to, m);
      got = obs();
      checks++;
      if ((got & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s tick k=%0d got=%h exp=%h mask=%h", name, k, got, e, m);
      end
      pe = e;
      pm = m;
      if (k == abort_at) return;
    end
    model_to = to;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    got = obs();
    checks++;
    if (got !== idle_vec(1'b0)) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", got, idle_vec(1'b0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_write("single", 1'b0, 8'h28, 8'hF0, 0, 1, 1'b0, -1);
  endtask

  task automatic test_part2_busy();
    do_write("part2_busy", 1'b1, 8'hB4, 8'hC0, 5, 1, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      do_write("random", 1'($urandom), 8'($urandom), 8'($urandom),
               int'($urandom_range(0, 12)), int'($urandom_range(1, 3)), 1'b0, -1);
  endtask

  task automatic test_timeout();
    do_write("timeout", 1'b0, 8'h2A, 8'h55, 1000, 1, 1'b0, -1);
    do_write("timeout_clear", 1'b1, 8'h30, 8'h0F, 2, 1, 1'b0, -1);
  endtask

  task automatic test_cen_gating();
    do_write("cen_gating", 1'b1, 8'h40, 8'h7F, 3, 6, 1'b0, -1);
  endtask

  task automatic test_ignored();
    logic [14:0] got;
    cen = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_reg   = 8'hEE;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    cen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got = obs();
      checks++;
      if (got !== idle_vec(model_to)) begin
        errors++;
        $display("FAIL ignored i=%0d got=%h exp=%h", i, got, idle_vec(model_to));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] got;
    do_write("reset_mid", 1'b1, 8'hA0, 8'h3C, 0, 1, 1'b0, WR_LEN + 1);
    #3;
    rst_n = 1'b0;
    #1;
    got = obs();
    checks++;
    if (got !== idle_vec(1'b0)) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", got, idle_vec(1'b0));
    end
    @(posedge clk); #1;
    got = obs();
    checks++;
    if (got !== idle_vec(1'b0)) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", got, idle_vec(1'b0));
    end
    rst_n = 1'b1;
    model_to = 1'b0;
    do_write("after_reset", 1'b0, 8'h22, 8'h08, 1, 1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    do_write("b2b_0", 1'b0, 8'h11, 8'hA1, 0, 1, 1'b1, -1);
    do_write("b2b_1", 1'b1, 8'h12, 8'hA2, 2, 1, 1'b1, -1);
    do_write("b2b_2", 1'b0, 8'h13, 8'hA3, 1, 1, 1'b0, -1);
    test_ignored();
  endtask

  initial begin
    rst_n = 1'b0;
    cen   = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_part  = 1'b0;
    bus_if.req_reg   = 8'h00;
    bus_if.req_data  = 8'h00;
    bus_if.ym_dout   = 8'h00;
    #12;
    test_reset();
    test_single();
    test_part2_busy();
    test_random();
    test_timeout();
    test_cen_gating();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
